// File: rtl/evg_code_injector.sv
// evg_code_injector
//   Queues processor-written event codes in a small FIFO and offers them to
//   the event transmitter one at a time over a valid/ready handshake, with a
//   programmable idle gap after each accepted code.
//
//   Write decode (on csrStrobe):
//     GPIO_OUT[7:0] code, [8] push, [9] flush, [10] enable
//   Read-back (status):
//     [7:0] last code, [8] empty, [9] full, [10] enable, [11] busy,
//     [23:16] fill level, [31:24] drop count (0 unless enabled below)
//
//   Optional feature macro: EVG_INJECTOR_DROP_COUNT_EN
//     defined   -> saturating 8-bit count of pushes lost to a full FIFO
//     undefined -> no counter hardware, status[31:24] reads 0
module evg_code_injector #(
    parameter string DEBUG   = "false",
    parameter int    FIFO_AW = 4,
    parameter int    MIN_GAP = 4
) (
    input  logic        sysClk,
    input  logic        sysReset_n,
    input  logic [31:0] GPIO_OUT,
    input  logic        csrStrobe,
    output logic [31:0] status,
    output logic [7:0]  txCode,
    output logic        txCodeValid,
    input  logic        txCodeReady
);

    localparam int unsigned      DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [7:0]       GAP_INIT = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    // Debug builds carry a marker scope in the elaborated hierarchy.
    if (DEBUG == "true") begin : g_debug_build
    end

    // ------------------------------------------------------------------
    // Processor write decode
    // ------------------------------------------------------------------
    logic        push_req;
    logic        flush;
    logic [7:0]  push_code;
    logic [20:0] unused_gpio;

    assign push_req    = csrStrobe && GPIO_OUT[8];
    assign flush       = csrStrobe && GPIO_OUT[9];
    assign push_code   = GPIO_OUT[7:0];
    assign unused_gpio = GPIO_OUT[31:11];

    (* mark_debug = DEBUG *) logic enable;

    // Enable follows GPIO_OUT[10] on every strobe.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            enable <= 1'b0;
        end else if (csrStrobe) begin
            enable <= GPIO_OUT[10];
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    (* mark_debug = DEBUG *) logic [7:0]         mem [DEPTH];
    (* mark_debug = DEBUG *) logic [FIFO_AW-1:0] wr_ptr;
    (* mark_debug = DEBUG *) logic [FIFO_AW-1:0] rd_ptr;
    (* mark_debug = DEBUG *) logic [FIFO_AW:0]   count;
    (* mark_debug = DEBUG *) logic               empty;
    (* mark_debug = DEBUG *) logic               full;
    (* mark_debug = DEBUG *) logic               wr_en;
    (* mark_debug = DEBUG *) logic               pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Null codes are ignored outright; full is the registered occupancy, so a
    // push into a full FIFO is lost even if a pop frees a slot on that edge.
    assign wr_en = push_req && (push_code != 8'h00) && !full && !flush;

    // Storage array; no reset needed since occupancy is tracked by count.
    always_ff @(posedge sysClk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_code;
        end
    end

    // Pointers and fill level; flush returns everything to the empty state.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM
    // ------------------------------------------------------------------
    (* mark_debug = DEBUG *) state_t     state_q;
    (* mark_debug = DEBUG *) state_t     state_d;
    (* mark_debug = DEBUG *) logic [7:0] gap_cnt;
    (* mark_debug = DEBUG *) logic [7:0] tx_code;
    (* mark_debug = DEBUG *) logic [7:0] last_code;
    logic handshake;
    logic gap_load;
    logic gap_dec;

    // State register.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes. A flush blocks the pop from IDLE so
    // nothing flushed can leak out; a code already in PRESENT is unaffected.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        handshake = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !empty && !flush) begin
                    pop     = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (txCodeReady) begin
                    handshake = 1'b1;
                    if (MIN_GAP > 0) begin
                        gap_load = 1'b1;
                        state_d  = GAP;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: presented code, last accepted code and gap down-counter.
    // The counter is loaded with MIN_GAP-1 so GAP lasts exactly MIN_GAP cycles.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            tx_code   <= '0;
            last_code <= '0;
            gap_cnt   <= '0;
        end else begin
            if (pop) begin
                tx_code <= mem[rd_ptr];
            end
            if (handshake) begin
                last_code <= tx_code;
            end
            if (gap_load) begin
                gap_cnt <= GAP_INIT;
            end else if (gap_dec) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    assign txCode      = tx_code;
    assign txCodeValid = (state_q == PRESENT);

    // ------------------------------------------------------------------
    // Drop counter (optional)
    // ------------------------------------------------------------------
    logic [7:0] drop_status;

`ifdef EVG_INJECTOR_DROP_COUNT_EN
    logic       drop_evt;
    logic [7:0] drop_cnt;

    assign drop_evt = push_req && (push_code != 8'h00) && full && !flush;

    // Saturating count of pushes lost to a full FIFO; cleared by flush.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_status = drop_cnt;
`else
    assign drop_status = '0;
`endif

    // ------------------------------------------------------------------
    // Status read-back
    // ------------------------------------------------------------------
    logic busy;
    assign busy = (state_q != IDLE);

    assign status = {drop_status, 8'(count), 4'b0000, busy, enable, full, empty, last_code};

endmodule

// File: tb/tb_evg_code_injector.sv
// tb_evg_code_injector
//   Table-driven write/status vectors plus hand-written multi-cycle sequences.
//   Emitted codes are checked against a queue of expected codes filled when
//   each push is driven.
module tb_evg_code_injector;

    localparam int FIFO_AW = 4;
    localparam int MIN_GAP = 4;

`ifdef EVG_INJECTOR_DROP_COUNT_EN
    localparam logic [7:0] EXP_DROP1   = 8'd1;
    localparam logic [7:0] EXP_DROPSAT = 8'd255;
`else
    localparam logic [7:0] EXP_DROP1   = 8'd0;
    localparam logic [7:0] EXP_DROPSAT = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpio = '0;
    logic        strobe = 1'b0;
    logic [31:0] status;
    logic [7:0]  tx_code;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    always #5 clk = ~clk;

    evg_code_injector #(
        .DEBUG   ("false"),
        .FIFO_AW (FIFO_AW),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .sysClk      (clk),
        .sysReset_n  (rst_n),
        .GPIO_OUT    (gpio),
        .csrStrobe   (strobe),
        .status      (status),
        .txCode      (tx_code),
        .txCodeValid (tx_valid),
        .txCodeReady (tx_ready)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_q[$];
    int unsigned hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake_code: got=%h required=none", tx_code);
            end else begin
                check("handshake_code", 32'(tx_code), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] d);
        gpio   = d;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        gpio   = '0;
    endtask

    task automatic wait_valid(input string name, input int unsigned limit);
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got=no_valid required=valid_within_%0d", name, limit);
        end
    endtask

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", status, 32'h0000_0100);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_code", 32'(tx_code), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // ---------------- single push latency ----------------
        tx_ready = 1'b1;
        exp_q.push_back(8'h7D);
        write(32'h0000_057D);
        @(negedge clk);
        check("a_valid_c1", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("a_valid_c2", 32'(tx_valid), 32'd1);
        check("a_code_c2", 32'(tx_code), 32'h7D);
        @(negedge clk);
        check("a_valid_c3", 32'(tx_valid), 32'd0);
        check("a_last_code", 32'(status[7:0]), 32'h7D);
        check("a_busy_gap", 32'(status[11]), 32'd1);
        repeat (8) tick();

        // ---------------- back-to-back spacing ----------------
        hs_cyc.delete();
        exp_q.push_back(8'h01);
        write(32'h0000_0501);
        exp_q.push_back(8'h02);
        write(32'h0000_0502);
        exp_q.push_back(8'h03);
        write(32'h0000_0503);
        repeat (30) tick();
        check("b_hs_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            check("b_space_01", 32'(hs_cyc[1] - hs_cyc[0]), 32'(MIN_GAP + 2));
            check("b_space_12", 32'(hs_cyc[2] - hs_cyc[1]), 32'(MIN_GAP + 2));
        end

        // ---------------- back-pressure hold ----------------
        tx_ready = 1'b0;
        exp_q.push_back(8'h55);
        write(32'h0000_0555);
        wait_valid("c_wait_valid", 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("c_hold", {23'd0, tx_valid, tx_code}, {23'd0, 1'b1, 8'h55});
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        @(negedge clk);
        check("c_valid_at_hs", 32'(tx_valid), 32'd1);
        @(negedge clk);
        check("c_valid_after", 32'(tx_valid), 32'd0);
        check("c_busy_gap", 32'(status[11]), 32'd1);
        repeat (8) tick();

        // ---------------- table: write decode with enable=0 ----------------
        vecs[0] = '{32'h0000_0000, 32'h0000_0155};
        vecs[1] = '{32'h0000_0111, 32'h0001_0055};
        vecs[2] = '{32'h0000_0100, 32'h0001_0055};
        vecs[3] = '{32'h0000_0122, 32'h0002_0055};
        vecs[4] = '{32'h0000_01FF, 32'h0003_0055};
        vecs[5] = '{32'h0000_0200, 32'h0000_0155};
        vecs[6] = '{32'h0000_0333, 32'h0000_0155};
        vecs[7] = '{32'h0000_0144, 32'h0001_0055};
        for (int i = 0; i < 8; i++) begin
            write(vecs[i].wdata);
            @(negedge clk);
            check($sformatf("tbl_%0d", i), status, vecs[i].exp_status);
        end
        exp_q.push_back(8'h44);
        write(32'h0000_0400);
        wait_valid("t_wait_valid", 6);
        repeat (10) tick();
        check("t_drained", status, 32'h0000_0544);

        // ---------------- fill, drop, null, flush ----------------
        write(32'h0000_0000);
        for (int i = 0; i < 17; i++) begin
            write(32'h0000_0180 + 32'(i));
        end
        @(negedge clk);
        check("d_full_status", status, {EXP_DROP1, 24'h10_0244});
        write(32'h0000_0100);
        @(negedge clk);
        check("d_null_push", status, {EXP_DROP1, 24'h10_0244});
        for (int i = 0; i < 260; i++) begin
            write(32'h0000_01AA);
        end
        @(negedge clk);
        check("d_drop_sat", 32'(status[31:24]), 32'(EXP_DROPSAT));
        write(32'h0000_0200);
        @(negedge clk);
        check("d_flush", status, 32'h0000_0144);

        // ---------------- flush during PRESENT ----------------
        tx_ready = 1'b0;
        exp_q.push_back(8'h40);
        write(32'h0000_0540);
        write(32'h0000_0541);
        write(32'h0000_0542);
        write(32'h0000_0543);
        @(negedge clk);
        check("e_present", {23'd0, tx_valid, tx_code}, {23'd0, 1'b1, 8'h40});
        check("e_fill3", 32'(status[23:16]), 32'd3);
        write(32'h0000_0600);
        @(negedge clk);
        check("e_hold_after_flush", {23'd0, tx_valid, tx_code}, {23'd0, 1'b1, 8'h40});
        check("e_empty", 32'(status[8]), 32'd1);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (tx_valid) n_valid++;
        end
        check("e_valid_cycles", 32'(n_valid), 32'd1);
        check("e_empty_end", 32'(status[8]), 32'd1);

        // ---------------- reset mid-GAP ----------------
        tx_ready = 1'b1;
        exp_q.push_back(8'h66);
        write(32'h0000_0566);
        tick();
        tick();
        #2;
        check("f_in_gap", {30'd0, status[11], tx_valid}, {30'd0, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("f_rst_status", status, 32'h0000_0100);
        check("f_rst_out", {23'd0, tx_valid, tx_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h67);
        write(32'h0000_0567);
        wait_valid("f_wait_valid", 4);
        repeat (8) tick();

        // ---------------- reset during PRESENT ----------------
        tx_ready = 1'b0;
        write(32'h0000_0568);
        wait_valid("g_wait_valid", 4);
        #1;
        rst_n = 1'b0;
        #1;
        check("g_rst_valid", 32'(tx_valid), 32'd0);
        check("g_rst_status", status, 32'h0000_0100);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (5) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/evg_code_injector.md
EVG_CODE_INJECTOR -- requirements
Module: evg_code_injector

Interface
REQ-001 SHALL have parameter DEBUG, default "false": applied as mark_debug to the internal FIFO and FSM signals.
REQ-002 SHALL have parameter FIFO_AW, default 4: FIFO address width, so depth is 2**FIFO_AW; legal range 2..7.
REQ-003 SHALL have parameter MIN_GAP, default 4: idle cycles enforced after each accepted code; legal range 0..255.
REQ-004 SHALL have port sysClk  input  1  the single clock for all logic.
REQ-005 SHALL have port sysReset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port GPIO_OUT  input  32  processor write data.
REQ-007 SHALL have port csrStrobe  input  1  one-cycle write qualifier for GPIO_OUT.
REQ-008 SHALL have port status  output  32  processor read-back.
REQ-009 SHALL have port txCode  output  8  event code offered to the transmitter.
REQ-010 SHALL have port txCodeValid  output  1  txCode is valid.
REQ-011 SHALL have port txCodeReady  input  1  the transmitter accepts txCode.

Function
REQ-012 SHALL decode a write as: push = csrStrobe && GPIO_OUT[8], with code = GPIO_OUT[7:0]; flush = csrStrobe && GPIO_OUT[9].
REQ-013 SHALL register enable from GPIO_OUT[10] on every csrStrobe cycle.
REQ-014 SHALL silently discard a push of code 0x00 (null event): no write and no drop count.
REQ-015 SHALL write a push into the FIFO when the registered full flag is clear at that edge, even if a pop occurs in the same cycle.
REQ-016 SHALL discard a push made while full and increment the drop counter, which saturates at 255.
REQ-017 SHALL, on flush, empty the FIFO and clear the drop counter; on the same strobe, flush wins and the push is ignored.
REQ-018 SHALL let a code already in PRESENT (txCodeValid=1) complete its handshake across a flush.
REQ-019 SHALL implement FSM state IDLE: if enable && !empty, pop the head into txCode, assert txCodeValid on the next edge and enter PRESENT; otherwise stay in IDLE.
REQ-020 SHALL implement FSM state PRESENT: hold txCode and txCodeValid stable until txCodeReady=1; on that handshake edge, deassert txCodeValid and latch txCode as lastCode.
REQ-021 SHALL, after the PRESENT handshake, enter GAP when MIN_GAP>0, otherwise IDLE.
REQ-022 SHALL implement FSM state GAP: remain for exactly MIN_GAP cycles, then enter IDLE.
REQ-023 SHALL assert txCodeValid two cycles after the strobe edge for a push into an empty FIFO with enable=1 and the FSM in IDLE.
REQ-024 SHALL space consecutive handshakes by MIN_GAP+2 cycles when txCodeReady is held high.
REQ-025 SHALL, when enable is cleared, stop popping from IDLE while still accepting pushes; PRESENT and GAP run to completion.
REQ-026 SHALL map status as: [7:0] lastCode, [8] empty, [9] full, [10] enable, [11] busy (state != IDLE), [23:16] fill level zero-extended, [31:24] drop count (see REQ-030), others 0.
REQ-027 SHALL report a fill level from 0 to 2**FIFO_AW inclusive; write and read pointers wrap modulo the depth.

Reset
REQ-028 SHALL, while sysReset_n=0, asynchronously force: FIFO empty, state IDLE, txCodeValid=0, txCode=0x00, enable=0, lastCode=0x00, drop count=0, GAP counter=0.
REQ-029 SHALL, when reset is asserted during PRESENT, drop txCodeValid immediately; the code is lost and not counted.

Configuration
REQ-030 SHALL compile in the drop counter only when macro EVG_INJECTOR_DROP_COUNT_EN is defined; status[31:24] then reports it.
REQ-031 SHALL, without EVG_INJECTOR_DROP_COUNT_EN, contain no counter logic and tie status[31:24] to 0; the full-drop behaviour is otherwise unchanged.

Verification
REQ-032 SHALL cover: enable=1, MIN_GAP=4, ready=1, push 0x7D -> txCodeValid high 2 cycles after strobe for 1 cycle with txCode=0x7D, then status[7:0]=0x7D.
REQ-033 SHALL cover: push 0x01,0x02,0x03 back-to-back, ready=1 -> handshakes in order, 6 cycles apart.
REQ-034 SHALL cover: ready=0 for 10 cycles during PRESENT -> txCode and txCodeValid stable throughout; state is GAP the cycle after ready rises.
REQ-035 SHALL cover: enable=0, push 17 codes with FIFO_AW=4 -> full=1, fill=16, drop count=1; push 0x00 -> no change; flush -> empty=1, drop count=0.
REQ-036 SHALL cover: flush during PRESENT holding 0x40 with 3 more queued -> 0x40 still handshakes; no further valid; empty=1.
REQ-037 SHALL cover: sysReset_n pulsed low mid-GAP -> all outputs and status at reset values asynchronously; the next push emits normally.
